rd_dest_pipe: RTL and testbench
===============================

// Module: rd_dest_pipe
// PURPOSE
//   Parametrised successor of the stage-2 destination-address select. Picks the write
//   destination from rt, rd or a fixed link register, forces no-write for register 0,
//   and carries {valid, wen, addr} through a DEPTH-stage shift pipeline toward writeback.
//   Also compares two source addresses against every in-flight entry for hazard and
//   forwarding decisions. Sits between decode and the hazard/forward unit.
// PARAMETERS
//   AW        5   register address width
//   DEPTH     3   in-flight stages tracked (>=1); stage DEPTH-1 feeds writeback
//   LINK_REG  31  destination used for link (JAL-type) writes
//   SW        2   width of hit_stage_*; must satisfy 2**SW > DEPTH
// PORTS
//   clk          in   1      rising-edge clock
//   rst          in   1      synchronous, active-high reset
//   in_valid     in   1      decode slot holds a real instruction
//   rd_en_ctrl   in   1      instruction writes a register
//   rd_sel       in   2      00=rt 01=rd 10=LINK_REG 11=reserved (treated as no write)
//   rt, rd       in   AW     decoded register fields
//   stall        in   1      hold all stages
//   flush        in   1      kill all in-flight entries and the input
//   src_a, src_b in   AW     source addresses of the instruction now in decode
//   wb_en        out  1      stage DEPTH-1 valid and writing
//   wb_addr      out  AW     stage DEPTH-1 address; 0 when wb_en=0
//   hazard_a/_b  out  1      src matches a valid, writing, in-flight entry
//   hit_stage_a/_b out SW    1+index of youngest matching stage; 0 = no match
//   inflight_cnt out  SW     number of valid writing entries across all stages
// BEHAVIOUR
//   - Select (combinational): sel_addr = rt|rd|LINK_REG per rd_sel.
//     sel_wen = in_valid & rd_en_ctrl & (rd_sel!=11) & (sel_addr!=0).
//     sel_addr is forced to 0 whenever sel_wen=0. Never drive X.
//   - Stage regs s[0..DEPTH-1] = {v, wen, addr}. s[0] is youngest.
//   - Each edge, in priority order:
//     1. rst: all v/wen/addr <= 0.
//     2. flush: all v/wen/addr <= 0. Input is discarded. Flush overrides stall.
//     3. stall: all stages hold.
//     4. Otherwise: s[i] <= s[i-1] for i>0, and s[0] <= {in_valid, sel_wen, sel_addr}.
//   - wb_en = s[DEPTH-1].v & s[DEPTH-1].wen; wb_addr = s[DEPTH-1].addr (0 if !wb_en).
//     The entry leaves the tracked window on the next unstalled edge.
//   - Latency: input to wb_en is DEPTH unstalled edges.
//   - Hazard (combinational, from current regs):
//     match_a[i] = s[i].v & s[i].wen & (s[i].addr==src_a).
//     src_a==0 never matches. Same rule for b.
//     hazard_a = |match_a. hit_stage_a = i+1 for the lowest matching i.
//   - inflight_cnt is a registered counter. It is updated on the same edge as the
//     stages and equals popcount(v&wen) of the new stage contents; 0 after reset or flush.
//   - No bubbles are inserted internally; stall generation belongs to the hazard unit.
//   - DEPTH=1: single register. hit_stage is 0 or 1.
// TESTING
//   - Reset: rst=1 for 2 cycles with random inputs -> wb_en=0, wb_addr=0, cnt=0,
//     hazards 0.
//   - Select: rd_sel=01, rd=7 -> wb_addr=7 after DEPTH edges. rd_sel=10 -> 31.
//     rd_sel=11 -> wb_en=0. rd=0 -> wb_en=0, addr 0.
//   - Forwarding: back-to-back writes to r5 then r9; src_a=5 the next cycle
//     -> hazard_a=1, hit_stage_a=2. src_a=9 -> hit_stage_a=1.
//   - Duplicate dest: r5 written twice in a row -> hit_stage_a=1 (youngest wins).
//   - Stall: stall=1 for 3 cycles mid-stream -> outputs and cnt frozen; sequence
//     resumes intact and wb order is preserved.
//   - Flush with stall both high and 3 entries in flight -> next cycle cnt=0,
//     wb_en=0, no hazards; input is not captured.

Source files
------------

// File: rtl/rd_dest_pipe.sv
// Write-destination select plus a DEPTH-stage {valid, wen, addr} pipeline toward writeback,
// with source-address hazard/forwarding lookup against every in-flight stage.
module rd_dest_pipe #(
    parameter int AW       = 5,
    parameter int DEPTH    = 3,
    parameter int LINK_REG = 31,
    parameter int SW       = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic          rd_en_ctrl,
    input  logic [1:0]    rd_sel,
    input  logic [AW-1:0] rt,
    input  logic [AW-1:0] rd,
    input  logic          stall,
    input  logic          flush,
    input  logic [AW-1:0] src_a,
    input  logic [AW-1:0] src_b,
    output logic          wb_en,
    output logic [AW-1:0] wb_addr,
    output logic          hazard_a,
    output logic          hazard_b,
    output logic [SW-1:0] hit_stage_a,
    output logic [SW-1:0] hit_stage_b,
    output logic [SW-1:0] inflight_cnt
);

    localparam logic [AW-1:0] LINK_ADDR = AW'(LINK_REG);

    logic [AW-1:0] sel_addr_raw;
    logic [AW-1:0] sel_addr;
    logic          sel_wen;

    logic [DEPTH-1:0]         v_q, v_d;
    logic [DEPTH-1:0]         wen_q, wen_d;
    logic [DEPTH-1:0][AW-1:0] addr_q, addr_d;
    logic [SW-1:0]            cnt_q, cnt_d;
    logic [DEPTH-1:0]         match_a, match_b;

    always_comb begin
        sel_addr_raw = '0;
        case (rd_sel)
            2'b00:   sel_addr_raw = rt;
            2'b01:   sel_addr_raw = rd;
            2'b10:   sel_addr_raw = LINK_ADDR;
            default: sel_addr_raw = '0;
        endcase
    end

    // Register 0 and the reserved select both collapse to a clean no-write with addr 0.
    assign sel_wen  = in_valid & rd_en_ctrl & (rd_sel != 2'b11) & (sel_addr_raw != '0);
    assign sel_addr = sel_wen ? sel_addr_raw : '0;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
        logic          v_prev;
        logic          wen_prev;
        logic [AW-1:0] addr_prev;

        if (gi == 0) begin : g_head
            assign v_prev    = in_valid;
            assign wen_prev  = sel_wen;
            assign addr_prev = sel_addr;
        end else begin : g_tail
            assign v_prev    = v_q[gi-1];
            assign wen_prev  = wen_q[gi-1];
            assign addr_prev = addr_q[gi-1];
        end

        // Flush wins over stall; stall holds every stage in place.
        assign v_d[gi]    = flush ? 1'b0 : (stall ? v_q[gi]    : v_prev);
        assign wen_d[gi]  = flush ? 1'b0 : (stall ? wen_q[gi]  : wen_prev);
        assign addr_d[gi] = flush ? '0   : (stall ? addr_q[gi] : addr_prev);

        assign match_a[gi] = v_q[gi] & wen_q[gi] & (addr_q[gi] == src_a) & (src_a != '0);
        assign match_b[gi] = v_q[gi] & wen_q[gi] & (addr_q[gi] == src_b) & (src_b != '0);
    end

    always_comb begin
        cnt_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            cnt_d = cnt_d + SW'(v_d[i] & wen_d[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v_q    <= '0;
            wen_q  <= '0;
            addr_q <= '0;
            cnt_q  <= '0;
        end else begin
            v_q    <= v_d;
            wen_q  <= wen_d;
            addr_q <= addr_d;
            cnt_q  <= cnt_d;
        end
    end

    // Scan oldest to youngest so the youngest match is the one left standing.
    always_comb begin
        hit_stage_a = '0;
        hit_stage_b = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (match_a[i]) hit_stage_a = SW'(i + 1);
            if (match_b[i]) hit_stage_b = SW'(i + 1);
        end
    end

    assign hazard_a     = |match_a;
    assign hazard_b     = |match_b;
    assign wb_en        = v_q[DEPTH-1] & wen_q[DEPTH-1];
    assign wb_addr      = wb_en ? addr_q[DEPTH-1] : '0;
    assign inflight_cnt = cnt_q;

endmodule

// File: tb/tb_rd_dest_pipe.sv
// Directed bench for rd_dest_pipe: queue-based reference model checked every cycle,
// plus literal expectations at the interesting points of each scenario.
module tb_rd_dest_pipe;

    localparam int AW       = 5;
    localparam int DEPTH    = 3;
    localparam int LINK_REG = 31;
    localparam int SW       = 2;

    logic          clk = 1'b0;
    logic          rst, in_valid, rd_en_ctrl, stall, flush;
    logic [1:0]    rd_sel;
    logic [AW-1:0] rt, rd, src_a, src_b;
    logic          wb_en, hazard_a, hazard_b;
    logic [AW-1:0] wb_addr;
    logic [SW-1:0] hit_stage_a, hit_stage_b, inflight_cnt;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    typedef struct {
        bit v;
        bit w;
        int a;
    } ent_t;
    ent_t mq[$];

    always #5 clk = ~clk;

    rd_dest_pipe #(.AW(AW), .DEPTH(DEPTH), .LINK_REG(LINK_REG), .SW(SW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .rd_en_ctrl(rd_en_ctrl),
        .rd_sel(rd_sel), .rt(rt), .rd(rd), .stall(stall), .flush(flush),
        .src_a(src_a), .src_b(src_b), .wb_en(wb_en), .wb_addr(wb_addr),
        .hazard_a(hazard_a), .hazard_b(hazard_b), .hit_stage_a(hit_stage_a),
        .hit_stage_b(hit_stage_b), .inflight_cnt(inflight_cnt)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a list of in-flight entries, youngest first.
    function automatic ent_t model_select();
        ent_t e;
        e.v = in_valid;
        case (rd_sel)
            2'd0:    e.a = int'(rt);
            2'd1:    e.a = int'(rd);
            2'd2:    e.a = LINK_REG;
            default: e.a = 0;
        endcase
        e.w = in_valid && rd_en_ctrl && rd_sel != 2'd3 && e.a != 0;
        if (!e.w) e.a = 0;
        return e;
    endfunction

    function automatic int m_hit(input logic [AW-1:0] s);
        for (int i = 0; i < DEPTH; i++) begin
            if (mq[i].v && mq[i].w && s != 0 && mq[i].a == int'(s)) return i + 1;
        end
        return 0;
    endfunction

    function automatic int m_cnt();
        int n = 0;
        foreach (mq[i]) if (mq[i].v && mq[i].w) n++;
        return n;
    endfunction

    always @(posedge clk) begin
        ent_t e;
        e = model_select();
        if (rst || flush) begin
            ent_t z;
            z.v = 1'b0; z.w = 1'b0; z.a = 0;
            mq.delete();
            for (int i = 0; i < DEPTH; i++) mq.push_back(z);
        end else if (!stall) begin
            mq.push_front(e);
            void'(mq.pop_back());
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            bit e_en;
            e_en = mq[DEPTH-1].v && mq[DEPTH-1].w;
            chk("m_wb_en", 32'(wb_en), 32'(e_en));
            chk("m_wb_addr", 32'(wb_addr), e_en ? mq[DEPTH-1].a : 0);
            chk("m_cnt", 32'(inflight_cnt), m_cnt());
            chk("m_hazard_a", 32'(hazard_a), 32'(m_hit(src_a) != 0));
            chk("m_hazard_b", 32'(hazard_b), 32'(m_hit(src_b) != 0));
            chk("m_hit_a", 32'(hit_stage_a), m_hit(src_a));
            chk("m_hit_b", 32'(hit_stage_b), m_hit(src_b));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input bit v, input bit en, input bit [1:0] sel, input int rtv, input int rdv);
        in_valid   = v;
        rd_en_ctrl = en;
        rd_sel     = sel;
        rt         = AW'(rtv);
        rd         = AW'(rdv);
    endtask

    task automatic idle();
        set_in(1'b0, 1'b0, 2'd0, 0, 0);
    endtask

    task automatic send(input bit [1:0] sel, input int rtv, input int rdv);
        set_in(1'b1, 1'b1, sel, rtv, rdv);
        $display("tx sel=%0d rt=%0d rd=%0d stall=%0b flush=%0b", sel, rtv, rdv, stall, flush);
        cyc();
        idle();
    endtask

    task automatic drain();
        idle();
        repeat (DEPTH + 1) cyc();
    endtask

    initial begin
        // Reset with random inputs on every other port.
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            in_valid = 1'($urandom); rd_en_ctrl = 1'($urandom); rd_sel = 2'($urandom);
            rt = AW'($urandom); rd = AW'($urandom); stall = 1'($urandom); flush = 1'($urandom);
            src_a = AW'($urandom); src_b = AW'($urandom);
            cyc();
            chk_en = 1'b1;
        end
        chk("rst_wb_en", 32'(wb_en), 0);
        chk("rst_wb_addr", 32'(wb_addr), 0);
        chk("rst_cnt", 32'(inflight_cnt), 0);
        chk("rst_hazard_a", 32'(hazard_a), 0);
        chk("rst_hazard_b", 32'(hazard_b), 0);
        rst = 1'b0; stall = 1'b0; flush = 1'b0; src_a = '0; src_b = '0;
        idle();
        cyc();

        // Destination select.
        send(2'd1, 3, 7);
        chk("sel_rd_cnt", 32'(inflight_cnt), 1);
        repeat (DEPTH - 1) cyc();
        chk("sel_rd_wb_en", 32'(wb_en), 1);
        chk("sel_rd_wb_addr", 32'(wb_addr), 7);
        drain();
        send(2'd2, 3, 7);
        repeat (DEPTH - 1) cyc();
        chk("sel_link_wb_addr", 32'(wb_addr), 31);
        drain();
        send(2'd3, 3, 7);
        chk("sel_rsvd_cnt", 32'(inflight_cnt), 0);
        repeat (DEPTH - 1) cyc();
        chk("sel_rsvd_wb_en", 32'(wb_en), 0);
        drain();
        send(2'd1, 3, 0);
        repeat (DEPTH - 1) cyc();
        chk("sel_r0_wb_en", 32'(wb_en), 0);
        chk("sel_r0_wb_addr", 32'(wb_addr), 0);
        drain();
        send(2'd0, 12, 7);
        repeat (DEPTH - 1) cyc();
        chk("sel_rt_wb_addr", 32'(wb_addr), 12);
        drain();

        // Forwarding: r5 then r9 back to back.
        set_in(1'b1, 1'b1, 2'd1, 0, 5); cyc();
        set_in(1'b1, 1'b1, 2'd1, 0, 9); cyc();
        idle();
        src_a = 5'd5; src_b = 5'd9; #1;
        chk("fwd_hazard_a", 32'(hazard_a), 1);
        chk("fwd_hit_a_r5", 32'(hit_stage_a), 2);
        chk("fwd_hit_b_r9", 32'(hit_stage_b), 1);
        src_a = 5'd9; #1;
        chk("fwd_hit_a_r9", 32'(hit_stage_a), 1);
        src_a = 5'd0; src_b = 5'd7; #1;
        chk("fwd_r0_hazard_a", 32'(hazard_a), 0);
        chk("fwd_miss_hazard_b", 32'(hazard_b), 0);
        src_b = 5'd0;
        drain();

        // Duplicate destination: youngest copy wins.
        set_in(1'b1, 1'b1, 2'd1, 0, 5); cyc();
        set_in(1'b1, 1'b1, 2'd1, 0, 5); cyc();
        idle();
        src_a = 5'd5; #1;
        chk("dup_hazard_a", 32'(hazard_a), 1);
        chk("dup_hit_a", 32'(hit_stage_a), 1);
        chk("dup_cnt", 32'(inflight_cnt), 2);
        src_a = 5'd0;
        drain();

        // Stall mid-stream for 3 cycles.
        set_in(1'b1, 1'b1, 2'd1, 0, 10); cyc();
        set_in(1'b1, 1'b1, 2'd1, 0, 11); cyc();
        set_in(1'b1, 1'b1, 2'd1, 0, 12); cyc();
        chk("stl_pre_wb_addr", 32'(wb_addr), 10);
        chk("stl_pre_cnt", 32'(inflight_cnt), 3);
        set_in(1'b1, 1'b1, 2'd1, 0, 13);
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("stl_hold_wb_addr", 32'(wb_addr), 10);
            chk("stl_hold_cnt", 32'(inflight_cnt), 3);
        end
        stall = 1'b0;
        cyc();
        chk("stl_resume_wb_11", 32'(wb_addr), 11);
        idle();
        cyc();
        chk("stl_resume_wb_12", 32'(wb_addr), 12);
        cyc();
        chk("stl_resume_wb_13", 32'(wb_addr), 13);
        cyc();
        chk("stl_empty_wb_en", 32'(wb_en), 0);
        chk("stl_empty_cnt", 32'(inflight_cnt), 0);
        drain();

        // Flush together with stall, three entries in flight.
        set_in(1'b1, 1'b1, 2'd1, 0, 20); cyc();
        set_in(1'b1, 1'b1, 2'd1, 0, 21); cyc();
        set_in(1'b1, 1'b1, 2'd1, 0, 22); cyc();
        set_in(1'b1, 1'b1, 2'd1, 0, 23);
        stall = 1'b1; flush = 1'b1;
        cyc();
        stall = 1'b0; flush = 1'b0;
        idle();
        chk("fl_cnt", 32'(inflight_cnt), 0);
        chk("fl_wb_en", 32'(wb_en), 0);
        src_a = 5'd22; src_b = 5'd23; #1;
        chk("fl_hazard_a", 32'(hazard_a), 0);
        chk("fl_hazard_b_input", 32'(hazard_b), 0);
        cyc();
        chk("fl_after_cnt", 32'(inflight_cnt), 0);
        src_a = '0; src_b = '0;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
